// File: rtl/tensor_pkg.sv
// tensor_pkg: shared arbiter state type and index-width helper
package tensor_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr_i
module rr_pick
  import tensor_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o
);
  logic hit;
  always_comb begin
    onehot_o = '0;
    idx_o = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && req_i[(int'(ptr_i) + k) % N]) begin
        hit = 1'b1;
        onehot_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = W'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin req/gnt sharing of one single-port sram with lockable bursts
module sram_arbiter
  import tensor_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_cs,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout
);
  localparam int W = idx_w(NUM_REQ);
  arb_state_e state_q;
  logic [W-1:0] ptr_q, ptr_d, owner_q, pick_idx, win_idx;
  logic [NUM_REQ-1:0] rd_pend_q, pick_oh;
  logic locked, grant;
  rr_pick #(.N(NUM_REQ), .W(W)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .onehot_o(pick_oh),
    .idx_o   (pick_idx)
  );
  // grants are held off while reset is asserted so outputs show their reset values
  always_comb begin
    locked = state_q == LOCKED;
    win_idx = locked ? owner_q : pick_idx;
    gnt = rst ? '0 : locked ? (NUM_REQ'(req[owner_q]) << owner_q) : pick_oh;
    grant = |gnt;
    mem_cs = grant;
    mem_we = grant & we[win_idx];
    mem_addr = grant ? addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_din = grant ? wdata[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    ptr_d = (pick_idx == W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      rd_pend_q <= '0;
    end else begin
      rd_pend_q <= (grant && !we[win_idx]) ? gnt : '0;
      if (state_q == IDLE && grant) begin
        ptr_q <= ptr_d;
        if (lock[win_idx]) begin
          owner_q <= win_idx;
          state_q <= LOCKED;
        end
      end else if (state_q == LOCKED && !lock[owner_q]) begin
        state_q <= IDLE;
      end
    end
  end
  assign rvalid = rd_pend_q;
  assign rdata = mem_dout;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboarded bench for the sram arbiter with a behavioural sram
module tb_sram_arbiter;
  localparam int N = 4, AW = 4, DW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, lock = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] sram [16];
  logic [DW-1:0] ref_mem [16];
  typedef struct {
    int due;
    logic [N-1:0] tag;
    logic [DW-1:0] data;
  } rd_t;
  rd_t sb [$];
  int total = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;
  sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_din;
      else mem_dout <= sram[mem_addr];
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  // check one cycle with the expected grant, then advance to the next falling edge
  task automatic tick(input string tag, input logic [N-1:0] eg);
    int w;
    logic [AW-1:0] a;
    rd_t e;
    #1;
    check({tag, " gnt"}, 32'(gnt), 32'(eg));
    check({tag, " cs"}, 32'(mem_cs), 32'(|eg));
    if (eg != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (eg[i]) w = i;
      a = addr[w*AW +: AW];
      check({tag, " addr"}, 32'(mem_addr), 32'(a));
      check({tag, " we"}, 32'(mem_we), 32'(we[w]));
      if (we[w]) begin
        check({tag, " din"}, 32'(mem_din), 32'(wdata[w*DW +: DW]));
        ref_mem[a] = wdata[w*DW +: DW];
      end else begin
        e.due = cyc + 1;
        e.tag = eg;
        e.data = ref_mem[a];
        sb.push_back(e);
      end
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check({tag, " rvalid"}, 32'(rvalid), 32'(sb[0].tag));
      check({tag, " rdata"}, 32'(rdata), 32'(sb[0].data));
      void'(sb.pop_front());
    end else begin
      check({tag, " rvalid"}, 32'(rvalid), 32'd0);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i] = 8'(i * 17 + 1);
      ref_mem[i] = 8'(i * 17 + 1);
    end
    sram[5] = 8'h3C;
    ref_mem[5] = 8'h3C;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst cs", 32'(mem_cs), 32'd0);
    check("rst we", 32'(mem_we), 32'd0);
    check("rst addr", 32'(mem_addr), 32'd0);
    check("rst din", 32'(mem_din), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = 4'(i + 1);
    for (int k = 0; k < 8; k++) tick("rr", 4'(1 << (k % 4)));
    req = 4'b0001;
    addr[0 +: AW] = 4'd5;
    tick("rd1", 4'b0001);
    req = '0;
    tick("idle", 4'b0000);
    tick("idle2", 4'b0000);
    req = 4'b0111;
    lock = 4'b0010;
    addr = 16'h0321;
    tick("lk1", 4'b0010);
    tick("lk2", 4'b0010);
    lock = '0;
    tick("lk3", 4'b0010);
    req = 4'b0101;
    tick("lk4", 4'b0100);
    req = '0;
    tick("lk_idle", 4'b0000);
    req = 4'b0100;
    we = 4'b0100;
    addr[2*AW +: AW] = 4'd9;
    wdata[2*DW +: DW] = 8'hA5;
    tick("wr", 4'b0100);
    req = 4'b0001;
    we = '0;
    addr[0 +: AW] = 4'd9;
    tick("rd9", 4'b0001);
    req = '0;
    tick("rd9_idle", 4'b0000);
    check("wr mem", 32'(ref_mem[9]), 32'hA5);
    req = 4'b1000;
    lock = 4'b1000;
    addr[3*AW +: AW] = 4'd5;
    tick("lock3", 4'b1000);
    rst = 1'b1;
    #1;
    check("midrst gnt", 32'(gnt), 32'd0);
    check("midrst rvalid", 32'(rvalid), 32'd0);
    check("midrst cs", 32'(mem_cs), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0011;
    lock = '0;
    tick("post", 4'b0001);
    req = '0;
    tick("post_idle", 4'b0000);
    tick("post_idle2", 4'b0000);
    check("sb empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
